// File: rtl/my8_accmachine.sv
// my8_accmachine: two-byte-instruction accumulator machine and bus master of my8_mem.
// Each bus access is an address cycle (mem_do=1) followed by a data cycle (mem_do=0).
// Bus controls and drive enables are registered together with the state, so every
// output reflects the current state with no combinational path from inputs.
module my8_accmachine (
    input  logic       m_clock,
    input  logic       p_reset,
    inout  wire  [7:0] adbus,
    output logic       mem_do,
    output logic       mem_rW,
    output logic [7:0] acc,
    output logic       zf,
    output logic       halted
);

    localparam int unsigned DW = 8;

    localparam logic [DW-1:0] OP_LDI = 8'h01;
    localparam logic [DW-1:0] OP_LDA = 8'h02;
    localparam logic [DW-1:0] OP_STA = 8'h03;
    localparam logic [DW-1:0] OP_ADD = 8'h04;
    localparam logic [DW-1:0] OP_SUB = 8'h05;
    localparam logic [DW-1:0] OP_JMP = 8'h06;
    localparam logic [DW-1:0] OP_JZ  = 8'h07;
    localparam logic [DW-1:0] OP_HLT = 8'h0F;

    typedef enum logic [3:0] {
        S_IDLE, S_FA, S_FD, S_OA, S_OD, S_EX, S_MA, S_MD, S_HALT
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   pc_q;
    logic [DW-1:0]   ir_q;
    logic [DW-1:0]   opr_q;
    logic [DW-1:0]   acc_q;
    logic            zf_q;
    logic            do_q;
    logic            rw_q;
    logic            oe_q;
    logic [DW-1:0]   bus_q;
    logic            halt_q;

    logic [DW-1:0]   alu_d;
    logic [DW-1:0]   ex_pc_d;
    logic            mem_op_d;

    // Result of a memory-operand instruction from the byte read in MD
    always_comb begin
        alu_d = adbus;
        case (ir_q)
            OP_ADD:  alu_d = DW'(acc_q + adbus);
            OP_SUB:  alu_d = DW'(acc_q - adbus);
            default: alu_d = adbus;
        endcase
    end

    // Program counter after EX: taken jumps load the operand
    always_comb begin
        ex_pc_d = pc_q;
        if ((ir_q == OP_JMP) || ((ir_q == OP_JZ) && zf_q)) begin
            ex_pc_d = opr_q;
        end
    end

    // Opcodes 0x02..0x05 take the memory-operand path
    always_comb begin
        mem_op_d = (ir_q >= OP_LDA) && (ir_q <= OP_SUB);
    end

    // Sequencer: state, architectural registers and registered bus controls
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            opr_q   <= '0;
            acc_q   <= '0;
            zf_q    <= 1'b0;
            do_q    <= 1'b0;
            rw_q    <= 1'b1;
            oe_q    <= 1'b0;
            bus_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            do_q <= 1'b0;
            rw_q <= 1'b1;
            oe_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FA;
                    do_q    <= 1'b1;
                    oe_q    <= 1'b1;
                    bus_q   <= pc_q;
                end
                S_FA: begin
                    state_q <= S_FD;
                end
                S_FD: begin
                    ir_q    <= adbus;
                    pc_q    <= DW'(pc_q + 8'd1);
                    state_q <= S_OA;
                    do_q    <= 1'b1;
                    oe_q    <= 1'b1;
                    bus_q   <= DW'(pc_q + 8'd1);
                end
                S_OA: begin
                    state_q <= S_OD;
                end
                S_OD: begin
                    opr_q <= adbus;
                    pc_q  <= DW'(pc_q + 8'd1);
                    if (mem_op_d) begin
                        state_q <= S_MA;
                        do_q    <= 1'b1;
                        oe_q    <= 1'b1;
                        rw_q    <= (ir_q != OP_STA);
                        bus_q   <= adbus;
                    end else begin
                        state_q <= S_EX;
                    end
                end
                S_EX: begin
                    pc_q <= ex_pc_d;
                    if (ir_q == OP_LDI) begin
                        acc_q <= opr_q;
                        zf_q  <= (opr_q == '0);
                    end
                    if (ir_q == OP_HLT) begin
                        state_q <= S_HALT;
                        halt_q  <= 1'b1;
                    end else begin
                        state_q <= S_FA;
                        do_q    <= 1'b1;
                        oe_q    <= 1'b1;
                        bus_q   <= ex_pc_d;
                    end
                end
                S_MA: begin
                    state_q <= S_MD;
                    if (ir_q == OP_STA) begin
                        oe_q  <= 1'b1;
                        bus_q <= acc_q;
                    end
                end
                S_MD: begin
                    if (ir_q != OP_STA) begin
                        acc_q <= alu_d;
                        zf_q  <= (alu_d == '0);
                    end
                    state_q <= S_FA;
                    do_q    <= 1'b1;
                    oe_q    <= 1'b1;
                    bus_q   <= pc_q;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign adbus  = oe_q ? bus_q : 8'hzz;
    assign mem_do = do_q;
    assign mem_rW = rw_q;
    assign acc    = acc_q;
    assign zf     = zf_q;
    assign halted = halt_q;

endmodule

// File: tb/tb_my8_accmachine.sv
// Bench for my8_accmachine: a my8_mem stand-in, an instruction-level reference model
// that expands each instruction into its expected bus cycles, and literal end checks.
module tb_my8_accmachine;

    logic       m_clock = 1'b0;
    logic       p_reset = 1'b1;
    wire  [7:0] adbus;
    logic       mem_do;
    logic       mem_rW;
    logic [7:0] acc;
    logic       zf;
    logic       halted;

    always #5 m_clock = ~m_clock;

    my8_accmachine dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .adbus   (adbus),
        .mem_do  (mem_do),
        .mem_rW  (mem_rW),
        .acc     (acc),
        .zf      (zf),
        .halted  (halted)
    );

    // Memory device: latches the request in the address cycle, serves the data cycle
    logic [7:0] img [256];
    logic [7:0] mem [256];
    logic       load_req   = 1'b0;
    logic       pend_q     = 1'b0;
    logic       dev_rw_q   = 1'b1;
    logic [7:0] dev_addr_q = 8'h00;
    wire        dev_oe     = pend_q && dev_rw_q;

    assign adbus = dev_oe ? mem[dev_addr_q] : 8'hzz;

    always @(posedge m_clock) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] = img[i];
        end
        if (!p_reset && pend_q && !dev_rw_q) mem[dev_addr_q] = adbus;
        if (p_reset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= mem_do;
            if (mem_do) begin
                dev_addr_q <= adbus;
                dev_rw_q   <= mem_rW;
            end
        end
    end

    // Expected per-cycle observation
    typedef struct packed {
        logic       d;    // mem_do
        logic       r;    // mem_rW
        logic       rc;   // mem_rW is checked
        logic       o;    // machine drives adbus
        logic [7:0] v;    // driven value
        logic       h;    // halted
        logic [7:0] a;    // acc
        logic       z;    // zf
    } rec_t;

    rec_t       exp_q [$];
    logic [7:0] fetch_log [$];
    logic [7:0] m_mem [256];
    logic [7:0] m_pc, m_acc;
    logic       m_zf, m_halt;
    logic [7:0] p_pc, p_acc, p_wa, p_wd;
    logic       p_zf, p_halt, p_wr;
    logic       have_pend;
    logic       prev_do;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%02h expected=%02h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input logic d, input logic r, input logic rc, input logic o,
                        input logic [7:0] v);
        rec_t x;
        x.d = d; x.r = r; x.rc = rc; x.o = o; x.v = v;
        x.h = m_halt; x.a = m_acc; x.z = m_zf;
        exp_q.push_back(x);
    endtask

    task automatic commit();
        m_pc = p_pc; m_acc = p_acc; m_zf = p_zf; m_halt = p_halt;
        if (p_wr) m_mem[p_wa] = p_wd;
    endtask

    // Execute one instruction at ISA level; queue its bus cycles, hold its effects pending
    task automatic gen_instr();
        logic [7:0] op, opr, a1, rd;
        p_pc = m_pc; p_acc = m_acc; p_zf = m_zf; p_halt = m_halt; p_wr = 1'b0;
        p_wa = 8'h00; p_wd = 8'h00;
        if (m_halt) begin
            push(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        end else begin
            a1  = m_pc + 8'd1;
            op  = m_mem[m_pc];
            opr = m_mem[a1];
            push(1'b1, 1'b1, 1'b1, 1'b1, m_pc);
            push(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            push(1'b1, 1'b1, 1'b1, 1'b1, a1);
            push(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            p_pc = a1 + 8'd1;
            if (op >= 8'h02 && op <= 8'h05) begin
                push(1'b1, op != 8'h03, 1'b1, 1'b1, opr);
                push(1'b0, 1'b1, 1'b0, op == 8'h03, m_acc);
                rd = m_mem[opr];
                case (op)
                    8'h02: p_acc = rd;
                    8'h04: p_acc = m_acc + rd;
                    8'h05: p_acc = m_acc - rd;
                    default: begin p_wr = 1'b1; p_wa = opr; p_wd = m_acc; end
                endcase
                if (op != 8'h03) p_zf = (p_acc == 8'h00);
            end else begin
                push(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
                case (op)
                    8'h01: begin p_acc = opr; p_zf = (opr == 8'h00); end
                    8'h06: p_pc = opr;
                    8'h07: if (m_zf) p_pc = opr;
                    8'h0F: p_halt = 1'b1;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc = 8'h00; m_acc = 8'h00; m_zf = 1'b0; m_halt = 1'b0;
        have_pend = 1'b0;
        prev_do = 1'b0;
        push(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    // One cycle of checking against the model plus the bus-protocol checks
    task automatic check_cycle();
        rec_t r;
        if (exp_q.size() == 0) begin
            if (have_pend) commit();
            gen_instr();
            have_pend = 1'b1;
        end
        r = exp_q.pop_front();
        chk("mem_do", 8'(mem_do), 8'(r.d));
        if (r.rc) chk("mem_rW", 8'(mem_rW), 8'(r.r));
        chk("bus_drive", 8'(dut.oe_q), 8'(r.o));
        if (r.o) chk("adbus", adbus, r.v);
        chk("halted", 8'(halted), 8'(r.h));
        chk("acc", acc, r.a);
        chk("zf", 8'(zf), 8'(r.z));
        chk("do_back_to_back", 8'(mem_do && prev_do), 8'h00);
        chk("multi_drive", 8'(dut.oe_q && dev_oe), 8'h00);
        if (mem_do) fetch_log.push_back(adbus);
        prev_do = mem_do;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            check_cycle();
            @(negedge m_clock);
            cyc++;
        end
    endtask

    // Reset, load img into device and model, release on a negedge (current cycle is IDLE)
    task automatic start_prog();
        @(negedge m_clock);
        p_reset  = 1'b1;
        load_req = 1'b1;
        @(negedge m_clock);
        load_req = 1'b0;
        @(negedge m_clock);
        for (int i = 0; i < 256; i++) m_mem[i] = img[i];
        fetch_log.delete();
        model_reset();
        cyc = 0;
        p_reset = 1'b0;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    initial begin
        int zcount;
        logic [7:0] ops [10];
        ops[0] = 8'h00; ops[1] = 8'h01; ops[2] = 8'h02; ops[3] = 8'h03; ops[4] = 8'h04;
        ops[5] = 8'h05; ops[6] = 8'h06; ops[7] = 8'h07; ops[8] = 8'h0F; ops[9] = 8'hA3;

        // LDI 5, ADD [10]=7, STA 20, HLT
        clear_img();
        img[0] = 8'h01; img[1] = 8'h05; img[2] = 8'h04; img[3] = 8'h10;
        img[4] = 8'h03; img[5] = 8'h20; img[6] = 8'h0F; img[7] = 8'h00;
        img[8'h10] = 8'h07;
        start_prog();
        chk("reset_mem_do", 8'(mem_do), 8'h00);
        chk("reset_mem_rW", 8'(mem_rW), 8'h01);
        chk("reset_halted", 8'(halted), 8'h00);
        chk("reset_acc", acc, 8'h00);
        run(30);
        chk("prog1_acc", acc, 8'h0C);
        chk("prog1_mem20", mem[8'h20], 8'h0C);
        chk("prog1_halted", 8'(halted), 8'h01);
        chk("prog1_zf", 8'(zf), 8'h00);

        // LDI 3, SUB [20]=3, JZ 0: loops forever
        clear_img();
        img[0] = 8'h01; img[1] = 8'h03; img[2] = 8'h05; img[3] = 8'h20;
        img[4] = 8'h07; img[5] = 8'h00; img[6] = 8'h0F; img[7] = 8'h00;
        img[8'h20] = 8'h03;
        start_prog();
        run(60);
        zcount = 0;
        foreach (fetch_log[i]) if (fetch_log[i] == 8'h00) zcount++;
        chk("prog2_loops", 8'(zcount >= 3), 8'h01);
        chk("prog2_halted", 8'(halted), 8'h00);
        chk("prog2_zf", 8'(zf), 8'h01);

        // LDI FF, ADD [10]=2 wraps to 1
        clear_img();
        img[0] = 8'h01; img[1] = 8'hFF; img[2] = 8'h04; img[3] = 8'h10;
        img[4] = 8'h0F; img[8'h10] = 8'h02;
        start_prog();
        run(25);
        chk("wrap_acc", acc, 8'h01);
        chk("wrap_zf", 8'(zf), 8'h00);

        // JMP FE, NOP at FE/FF, fetch wraps to 00
        clear_img();
        img[0] = 8'h06; img[1] = 8'hFE;
        start_prog();
        run(14);
        chk("pcwrap_n", 8'(fetch_log.size() >= 5), 8'h01);
        if (fetch_log.size() >= 5) begin
            chk("pcwrap_f2", fetch_log[2], 8'hFE);
            chk("pcwrap_f3", fetch_log[3], 8'hFF);
            chk("pcwrap_f4", fetch_log[4], 8'h00);
        end

        // Reset during MD of STA: no write, bus released, restart at 00
        clear_img();
        img[0] = 8'h01; img[1] = 8'h55; img[2] = 8'h03; img[3] = 8'h30;
        img[4] = 8'h0F; img[8'h30] = 8'hA5;
        start_prog();
        run(11);
        check_cycle();
        p_reset = 1'b1;
        @(negedge m_clock);
        cyc++;
        chk("rst_md_drive", 8'(dut.oe_q), 8'h00);
        chk("rst_md_mem_do", 8'(mem_do), 8'h00);
        chk("rst_md_mem_rW", 8'(mem_rW), 8'h01);
        chk("rst_md_acc", acc, 8'h00);
        chk("rst_md_nowrite", mem[8'h30], 8'hA5);
        fetch_log.delete();
        model_reset();
        p_reset = 1'b0;
        run(8);
        chk("rst_md_refetch", fetch_log[0], 8'h00);
        chk("rst_md_nowrite2", mem[8'h30], 8'hA5);

        // Random programs against the model
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 64; i += 2) begin
                img[i] = ops[$urandom_range(0, 9)];
                if (img[i] == 8'h06 || img[i] == 8'h07) img[i+1] = 8'($urandom_range(0, 31) * 2);
            end
            start_prog();
            run(300);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
